reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Integer register file plus per-register busy scoreboard. It is the receiving end of the
//  writeback stage's write port (rf_wr_en/rf_wr_reg/rf_wr_data). It serves two combinational
//  read ports to decode. Busy bits tell decode that a source register has an issued writer
//  still in flight. Sits between decode (reads, issue marking) and writeback (writes, busy clearing).
// PARAMETERS
//  XLEN    32  data width of each register
//  NREGS   32  number of architectural registers; register 0 is hardwired to zero
//  AW      5   register address width, clog2(NREGS)
// PORTS
//  clk_i         in   1     single clock; all state updates on rising edge
//  rst_ni        in   1     asynchronous, active-low reset
//  rs1_addr_i    in   AW    read port 1 address
//  rs2_addr_i    in   AW    read port 2 address
//  rs1_data_oa   out  XLEN  read port 1 data (combinational)
//  rs2_data_oa   out  XLEN  read port 2 data (combinational)
//  rs1_busy_oa   out  1     rs1 has an outstanding writer (combinational)
//  rs2_busy_oa   out  1     rs2 has an outstanding writer (combinational)
//  rf_wr_en_i    in   1     write enable from writeback
//  rf_wr_reg_i   in   AW    write address from writeback
//  rf_wr_data_i  in   XLEN  write data from writeback
//  issue_en_i    in   1     decode issues an instruction that writes issue_rd_i
//  issue_rd_i    in   AW    destination of the issued instruction
//  flush_i       in   1     pipeline flush: discard all outstanding writers
// BEHAVIOUR
//  Reset (rst_ni=0, async): all registers = 0; all busy bits = 0. The outputs are then
//   rs*_data_oa=0 and rs*_busy_oa=0 for any address. Reset asserted mid-cycle takes effect
//   immediately; a write in that cycle is lost.
//  Write: on posedge with rf_wr_en_i=1 and rf_wr_reg_i!=0, regs[rf_wr_reg_i] <= rf_wr_data_i.
//   Writes to register 0 are discarded.
//  Read: rsN_data_oa is 0 if rsN_addr_i==0.
//   Otherwise, if rf_wr_en_i && rf_wr_reg_i==rsN_addr_i, it is rf_wr_data_i (write-through bypass).
//   Otherwise it is regs[rsN_addr_i]. Zero-cycle latency; the two ports are independent,
//   and both may name the same register.
//  Busy state busy[r] is updated on each posedge in this priority order:
//   1. flush_i=1: all busy <= 0; issue_en_i in the same cycle is ignored.
//      The rf write still happens.
//   2. issue_en_i && issue_rd_i!=0: busy[issue_rd_i] <= 1. This wins over a same-cycle
//      clear of the same register, because the newer writer is still outstanding.
//   3. rf_wr_en_i && rf_wr_reg_i!=0: busy[rf_wr_reg_i] <= 0 (unless rule 2 hit the same register).
//  busy[0] is constant 0.
//  rsN_busy_oa = busy[rsN_addr_i] && !(rf_wr_en_i && rf_wr_reg_i==rsN_addr_i).
//   A register being written this cycle reads as not busy because its data is bypassed.
//   Exception: issue_rd_i names that same register this cycle; issue affects busy from the
//   next cycle only.
//  Single outstanding writer per register: issue_en_i to an rd whose busy bit is set is a
//   protocol violation (decode stalls instead). The bench asserts it never occurs.
//   The RTL need not handle it.
//  Out-of-range addresses (>= NREGS when NREGS < 2**AW): reads return 0 and busy=0;
//   writes and issues are ignored.
// TESTING
//  Reset: drive rst_ni=0 after writing x5=0xDEADBEEF -> rs1_data_oa(x5)=0 and rs1_busy_oa=0
//   immediately, without waiting for a clock edge.
//  Write/read: write x7=0x12345678 at cycle n, then read x7 on both ports at n+1 ->
//   both read 0x12345678. Write x0=0xFFFFFFFF -> x0 reads 0.
//  Bypass: in one cycle, rf_wr_en_i=1, x9=0xA5A5A5A5 while rs2_addr_i=9 and regs[9]=0 ->
//   rs2_data_oa=0xA5A5A5A5 in that same cycle.
//  Scoreboard: issue rd=3 -> rs1_busy_oa(3)=1 next cycle. WB writes x3 -> busy reads 0 in
//   the write cycle and after it. Same-cycle issue of x4 and WB write of x4 -> busy(4)=1 afterwards.
//  Flush: set busy on x1, x2, x31, then flush_i=1 together with issue rd=5 ->
//   all busy bits 0 next cycle, including x5.
//  Random: 10k cycles of random reads/writes/issues that respect the single-writer rule,
//   compared against a reference model -> zero mismatches, and x0 always reads 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Integer register file with per-register busy scoreboard; x0 reads as zero.
// Latency: reads and busy flags are combinational with write-through bypass; updates on the rising edge.
// Backpressure: none. Decode stalls on busy sources and never issues to a register that is already busy.
module reg_file_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   rs1_addr_i,
    input  logic [AW-1:0]   rs2_addr_i,
    output logic [XLEN-1:0] rs1_data_oa,
    output logic [XLEN-1:0] rs2_data_oa,
    output logic            rs1_busy_oa,
    output logic            rs2_busy_oa,
    input  logic            rf_wr_en_i,
    input  logic [AW-1:0]   rf_wr_reg_i,
    input  logic [XLEN-1:0] rf_wr_data_i,
    input  logic            issue_en_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic            flush_i
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic             wr_ok;
    logic             issue_ok;

    // Addresses at or above NREGS are treated as nonexistent registers.
    function automatic logic in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W);
    endfunction

    // A write or issue only counts when it targets a real, non-zero register.
    always_comb begin
        wr_ok    = rf_wr_en_i && (rf_wr_reg_i != '0) && in_range(rf_wr_reg_i);
        issue_ok = issue_en_i && (issue_rd_i != '0) && in_range(issue_rd_i);
    end

    // Register storage; a flush does not suppress the writeback write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[rf_wr_reg_i] <= rf_wr_data_i;
        end
    end

    // Busy scoreboard: flush clears everything, and an issue overrides a same-register writeback clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy <= '0;
        end else if (flush_i) begin
            busy <= '0;
        end else begin
            if (wr_ok) begin
                busy[rf_wr_reg_i] <= 1'b0;
            end
            if (issue_ok) begin
                busy[issue_rd_i] <= 1'b1;
            end
        end
    end

    // Read port 1: a register being written this cycle returns the new data and reads as not busy.
    always_comb begin
        rs1_data_oa = '0;
        rs1_busy_oa = 1'b0;
        if ((rs1_addr_i != '0) && in_range(rs1_addr_i)) begin
            if (rf_wr_en_i && (rf_wr_reg_i == rs1_addr_i)) begin
                rs1_data_oa = rf_wr_data_i;
            end else begin
                rs1_data_oa = regs[rs1_addr_i];
                rs1_busy_oa = busy[rs1_addr_i];
            end
        end
    end

    // Read port 2: identical to port 1 and fully independent of it.
    always_comb begin
        rs2_data_oa = '0;
        rs2_busy_oa = 1'b0;
        if ((rs2_addr_i != '0) && in_range(rs2_addr_i)) begin
            if (rf_wr_en_i && (rf_wr_reg_i == rs2_addr_i)) begin
                rs2_data_oa = rf_wr_data_i;
            end else begin
                rs2_data_oa = regs[rs2_addr_i];
                rs2_busy_oa = busy[rs2_addr_i];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and model-based bench for reg_file_sb.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// The design has no flow control, so there is nothing to stall on.
module tb_reg_file_sb;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic [31:0] rs1_data_oa, rs2_data_oa;
    logic        rs1_busy_oa, rs2_busy_oa;
    logic        rf_wr_en_i;
    logic [4:0]  rf_wr_reg_i;
    logic [31:0] rf_wr_data_i;
    logic        issue_en_i;
    logic [4:0]  issue_rd_i;
    logic        flush_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_data_oa  (rs1_data_oa),
        .rs2_data_oa  (rs2_data_oa),
        .rs1_busy_oa  (rs1_busy_oa),
        .rs2_busy_oa  (rs2_busy_oa),
        .rf_wr_en_i   (rf_wr_en_i),
        .rf_wr_reg_i  (rf_wr_reg_i),
        .rf_wr_data_i (rf_wr_data_i),
        .issue_en_i   (issue_en_i),
        .issue_rd_i   (issue_rd_i),
        .flush_i      (flush_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        rf_wr_en_i   = 1'b0;
        rf_wr_reg_i  = 5'd0;
        rf_wr_data_i = 32'd0;
        issue_en_i   = 1'b0;
        issue_rd_i   = 5'd0;
        flush_i      = 1'b0;
    endtask

    task automatic test_reset();
        // Reset held from time 0.
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd31;
        idle();
        #2;
        total_cnt++; if (rs1_data_oa !== 32'd0) $display("FAIL reset_rs1_data got=%h exp=0", rs1_data_oa); else pass_cnt++;
        total_cnt++; if (rs2_busy_oa !== 1'b0) $display("FAIL reset_rs2_busy got=%b exp=0", rs2_busy_oa); else pass_cnt++;
        @(negedge clk_i); rst_ni = 1'b1;
        // Write x5 and mark it busy in the same cycle.
        @(negedge clk_i);
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd5; rf_wr_data_i = 32'hDEADBEEF;
        issue_en_i = 1'b1; issue_rd_i = 5'd5;
        @(negedge clk_i); idle(); #1;
        total_cnt++; if (rs1_data_oa !== 32'hDEADBEEF) $display("FAIL pre_reset_x5 got=%h exp=deadbeef", rs1_data_oa); else pass_cnt++;
        total_cnt++; if (rs1_busy_oa !== 1'b1) $display("FAIL pre_reset_busy5 got=%b exp=1", rs1_busy_oa); else pass_cnt++;
        // Asynchronous reset mid-cycle.
        #1 rst_ni = 1'b0;
        #1;
        total_cnt++; if (rs1_data_oa !== 32'd0) $display("FAIL async_reset_x5 got=%h exp=0", rs1_data_oa); else pass_cnt++;
        total_cnt++; if (rs1_busy_oa !== 1'b0) $display("FAIL async_reset_busy5 got=%b exp=0", rs1_busy_oa); else pass_cnt++;
        @(negedge clk_i); rst_ni = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk_i);
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd7; rf_wr_data_i = 32'h12345678;
        @(negedge clk_i); idle();
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd7; #1;
        total_cnt++; if (rs1_data_oa !== 32'h12345678) $display("FAIL wr_rd_rs1_x7 got=%h exp=12345678", rs1_data_oa); else pass_cnt++;
        total_cnt++; if (rs2_data_oa !== 32'h12345678) $display("FAIL wr_rd_rs2_x7 got=%h exp=12345678", rs2_data_oa); else pass_cnt++;
        // Write to x0: no bypass and no storage.
        @(negedge clk_i);
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd0; rf_wr_data_i = 32'hFFFFFFFF;
        rs1_addr_i = 5'd0; #1;
        total_cnt++; if (rs1_data_oa !== 32'd0) $display("FAIL x0_bypass got=%h exp=0", rs1_data_oa); else pass_cnt++;
        @(negedge clk_i); idle(); #1;
        total_cnt++; if (rs1_data_oa !== 32'd0) $display("FAIL x0_after_write got=%h exp=0", rs1_data_oa); else pass_cnt++;
    endtask

    task automatic test_bypass();
        @(negedge clk_i);
        rs1_addr_i = 5'd9; rs2_addr_i = 5'd9; #1;
        total_cnt++; if (rs2_data_oa !== 32'd0) $display("FAIL bypass_pre_x9 got=%h exp=0", rs2_data_oa); else pass_cnt++;
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd9; rf_wr_data_i = 32'hA5A5A5A5;
        rs1_addr_i = 5'd7; #1;
        total_cnt++; if (rs2_data_oa !== 32'hA5A5A5A5) $display("FAIL bypass_rs2_x9 got=%h exp=a5a5a5a5", rs2_data_oa); else pass_cnt++;
        total_cnt++; if (rs1_data_oa !== 32'h12345678) $display("FAIL bypass_rs1_indep got=%h exp=12345678", rs1_data_oa); else pass_cnt++;
        @(negedge clk_i); idle();
    endtask

    task automatic test_scoreboard();
        @(negedge clk_i);
        issue_en_i = 1'b1; issue_rd_i = 5'd3; rs1_addr_i = 5'd3; #1;
        total_cnt++; if (rs1_busy_oa !== 1'b0) $display("FAIL sb_issue_same_cycle got=%b exp=0", rs1_busy_oa); else pass_cnt++;
        @(negedge clk_i); idle(); #1;
        total_cnt++; if (rs1_busy_oa !== 1'b1) $display("FAIL sb_busy3_set got=%b exp=1", rs1_busy_oa); else pass_cnt++;
        @(negedge clk_i);
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd3; rf_wr_data_i = 32'h00000033; #1;
        total_cnt++; if (rs1_busy_oa !== 1'b0) $display("FAIL sb_busy3_wb_cycle got=%b exp=0", rs1_busy_oa); else pass_cnt++;
        @(negedge clk_i); idle(); #1;
        total_cnt++; if (rs1_busy_oa !== 1'b0) $display("FAIL sb_busy3_after_wb got=%b exp=0", rs1_busy_oa); else pass_cnt++;
        // Issue and writeback of x4 together: issue wins.
        @(negedge clk_i);
        issue_en_i = 1'b1; issue_rd_i = 5'd4;
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd4; rf_wr_data_i = 32'h00000044;
        rs2_addr_i = 5'd4; #1;
        total_cnt++; if (rs2_busy_oa !== 1'b0) $display("FAIL sb_busy4_same_cycle got=%b exp=0", rs2_busy_oa); else pass_cnt++;
        @(negedge clk_i); idle(); #1;
        total_cnt++; if (rs2_busy_oa !== 1'b1) $display("FAIL sb_busy4_issue_wins got=%b exp=1", rs2_busy_oa); else pass_cnt++;
        total_cnt++; if (rs2_data_oa !== 32'h00000044) $display("FAIL sb_x4_data got=%h exp=00000044", rs2_data_oa); else pass_cnt++;
        @(negedge clk_i);
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd4; rf_wr_data_i = 32'h00000045;
        @(negedge clk_i); idle();
    endtask

    task automatic test_flush();
        @(negedge clk_i); issue_en_i = 1'b1; issue_rd_i = 5'd1;
        @(negedge clk_i); issue_rd_i = 5'd2;
        @(negedge clk_i); issue_rd_i = 5'd31;
        @(negedge clk_i);
        issue_en_i = 1'b1; issue_rd_i = 5'd5; flush_i = 1'b1;
        rf_wr_en_i = 1'b1; rf_wr_reg_i = 5'd10; rf_wr_data_i = 32'hCAFEF00D;
        rs1_addr_i = 5'd1; rs2_addr_i = 5'd31; #1;
        total_cnt++; if (rs1_busy_oa !== 1'b1) $display("FAIL flush_pre_busy1 got=%b exp=1", rs1_busy_oa); else pass_cnt++;
        total_cnt++; if (rs2_busy_oa !== 1'b1) $display("FAIL flush_pre_busy31 got=%b exp=1", rs2_busy_oa); else pass_cnt++;
        @(negedge clk_i); idle();
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd1; #1;
        total_cnt++; if (rs1_busy_oa !== 1'b0) $display("FAIL flush_busy5 got=%b exp=0", rs1_busy_oa); else pass_cnt++;
        total_cnt++; if (rs2_busy_oa !== 1'b0) $display("FAIL flush_busy1 got=%b exp=0", rs2_busy_oa); else pass_cnt++;
        rs1_addr_i = 5'd2; rs2_addr_i = 5'd31; #1;
        total_cnt++; if (rs1_busy_oa !== 1'b0) $display("FAIL flush_busy2 got=%b exp=0", rs1_busy_oa); else pass_cnt++;
        total_cnt++; if (rs2_busy_oa !== 1'b0) $display("FAIL flush_busy31 got=%b exp=0", rs2_busy_oa); else pass_cnt++;
        rs1_addr_i = 5'd10; #1;
        total_cnt++; if (rs1_data_oa !== 32'hCAFEF00D) $display("FAIL flush_write_kept got=%h exp=cafef00d", rs1_data_oa); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        b1, b2;
        int          errs;
        errs = 0;
        // Start the model from a known reset state.
        @(negedge clk_i); idle(); rst_ni = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_busy = 32'd0;
        @(negedge clk_i); rst_ni = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk_i);
            rs1_addr_i   = 5'($urandom_range(31, 0));
            rs2_addr_i   = 5'($urandom_range(31, 0));
            rf_wr_en_i   = ($urandom_range(1, 0) == 1);
            rf_wr_reg_i  = 5'($urandom_range(31, 0));
            rf_wr_data_i = $urandom;
            issue_rd_i   = 5'($urandom_range(31, 0));
            issue_en_i   = ($urandom_range(2, 0) == 0) && !m_busy[issue_rd_i];
            flush_i      = ($urandom_range(49, 0) == 0);
            assert (!(issue_en_i && issue_rd_i != 5'd0 && m_busy[issue_rd_i]))
                else $error("issue to a busy register");
            #1;
            e1 = (rs1_addr_i == 5'd0) ? 32'd0 : (rf_wr_en_i && rf_wr_reg_i == rs1_addr_i) ? rf_wr_data_i : m_regs[rs1_addr_i];
            e2 = (rs2_addr_i == 5'd0) ? 32'd0 : (rf_wr_en_i && rf_wr_reg_i == rs2_addr_i) ? rf_wr_data_i : m_regs[rs2_addr_i];
            b1 = m_busy[rs1_addr_i] && !(rf_wr_en_i && rf_wr_reg_i == rs1_addr_i);
            b2 = m_busy[rs2_addr_i] && !(rf_wr_en_i && rf_wr_reg_i == rs2_addr_i);
            if (rs1_data_oa !== e1 || rs2_data_oa !== e2 || rs1_busy_oa !== b1 || rs2_busy_oa !== b2) begin
                if (errs < 10)
                    $display("FAIL random cyc=%0d a1=%0d a2=%0d got d1=%h d2=%h b1=%b b2=%b exp d1=%h d2=%h b1=%b b2=%b",
                             cyc, rs1_addr_i, rs2_addr_i, rs1_data_oa, rs2_data_oa, rs1_busy_oa, rs2_busy_oa, e1, e2, b1, b2);
                errs++;
            end
            // Model next state.
            if (rf_wr_en_i && rf_wr_reg_i != 5'd0) m_regs[rf_wr_reg_i] = rf_wr_data_i;
            if (flush_i) begin
                m_busy = 32'd0;
            end else begin
                if (rf_wr_en_i && rf_wr_reg_i != 5'd0) m_busy[rf_wr_reg_i] = 1'b0;
                if (issue_en_i && issue_rd_i != 5'd0) m_busy[issue_rd_i] = 1'b1;
            end
        end
        total_cnt++; if (errs !== 0) $display("FAIL random_mismatches got=%0d exp=0", errs); else pass_cnt++;
        @(negedge clk_i); idle();
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0; #1;
        total_cnt++; if (rs1_data_oa !== 32'd0 || rs2_data_oa !== 32'd0) $display("FAIL random_x0 got=%h/%h exp=0", rs1_data_oa, rs2_data_oa); else pass_cnt++;
    endtask

    initial begin
        rst_ni = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
